// File: rtl/fp_pkg.sv
// Shared constants, operation encodings and the packed 24-bit float type
// used by the fp_std add/sub/max/min pipe.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 15;
  localparam int FP_BIAS  = 127;

  localparam logic [1:0] FP_OP_ADD = 2'b00;
  localparam logic [1:0] FP_OP_MAX = 2'b01;
  localparam logic [1:0] FP_OP_MIN = 2'b10;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] frac;
  } fp24_t;

  // Stage-0 register bank contents handed to fp_std_1
  typedef struct packed {
    logic [3:0]          op;
    logic                max_sign;
    logic                min_sign;
    logic [FP_EXP_W-1:0] max_exp;
    logic [16:0]         add_man;
    logic [15:0]         sub_man;
    logic [23:0]         max_res;
    logic [23:0]         min_res;
    logic [23:0]         result;
  } fp_std_0_out_t;

  function automatic logic [FP_MAN_W:0] fp_man(input fp24_t v);
    return {(v.exp != {FP_EXP_W{1'b0}}), v.frac};
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational 16-bit mantissa right shifter; shifts of 16 or more
// saturate to zero. Truncating, no guard/sticky bits.
module fp_align_shift (
  input  logic [15:0] man_i,
  input  logic [7:0]  shift_i,
  output logic [15:0] man_o
);

  // Saturating logical right shift
  always_comb begin
    man_o = 16'h0000;
    if (shift_i >= 8'd16) begin
      man_o = 16'h0000;
    end else begin
      man_o = man_i >> shift_i[3:0];
    end
  end

endmodule

// File: rtl/fp_std_0.sv
// First stage of the 24-bit float add/sub/max/min pipe: unpack, magnitude
// order, align, raw sum/difference and signed max/min into a stallable register.
module fp_std_0
  import fp_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  output logic [3:0]       op_o,
  output logic             max_sign_o,
  output logic             min_sign_o,
  output logic [7:0]       max_exponent_o,
  output logic [16:0]      add_result_mantissa_o,
  output logic [15:0]      sub_result_mantissa_o,
  output logic [WIDTH-1:0] max_result_o,
  output logic [WIDTH-1:0] min_result_o,
  output logic [WIDTH-1:0] result_o
);

  fp24_t         a_s, b_s, bn_s, max_op_s, min_op_s;
  logic          a_is_max_s;
  logic [7:0]    exp_diff_s;
  logic [15:0]   max_man_s, min_man_s, aligned_min_s;
  fp_std_0_out_t out_d, out_q;
  logic          valid_d, valid_q;

  assign a_s  = a_i;
  assign b_s  = b_i;

  // Unpack, magnitude ordering and signed max/min selection
  always_comb begin
    bn_s       = b_s;
    bn_s.sign  = b_s.sign ^ ((op_i[1:0] == FP_OP_ADD) & op_i[2]);
    a_is_max_s = ({a_s.exp, a_s.frac} >= {b_s.exp, b_s.frac});
    if (a_is_max_s) begin
      max_op_s = a_s;
      min_op_s = bn_s;
    end else begin
      max_op_s = bn_s;
      min_op_s = a_s;
    end
    max_man_s  = fp_man(max_op_s);
    min_man_s  = fp_man(min_op_s);
    exp_diff_s = max_op_s.exp - min_op_s.exp;

    out_d          = '{default: 1'b0};
    out_d.op       = op_i;
    out_d.max_sign = max_op_s.sign;
    out_d.min_sign = min_op_s.sign;
    out_d.max_exp  = max_op_s.exp;
    out_d.add_man  = {1'b0, max_man_s} + {1'b0, aligned_min_s};
    out_d.sub_man  = max_man_s - aligned_min_s;
    out_d.result   = a_s;
    // Raw (un-negated) b; both-negative case inverts the magnitude order
    if (a_s == b_s) begin
      out_d.max_res = a_s;
      out_d.min_res = a_s;
    end else if (a_s.sign != b_s.sign) begin
      out_d.max_res = a_s.sign ? b_s : a_s;
      out_d.min_res = a_s.sign ? a_s : b_s;
    end else if (!a_s.sign) begin
      out_d.max_res = a_is_max_s ? a_s : b_s;
      out_d.min_res = a_is_max_s ? b_s : a_s;
    end else begin
      out_d.max_res = a_is_max_s ? b_s : a_s;
      out_d.min_res = a_is_max_s ? a_s : b_s;
    end
    valid_d = valid_i;
  end

  fp_align_shift u_align (
    .man_i   (min_man_s),
    .shift_i (exp_diff_s),
    .man_o   (aligned_min_s)
  );

  // Pipeline register: reset wins over stall, stall holds everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q   <= '{default: 1'b0};
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end else begin
      out_q   <= out_q;
      valid_q <= valid_q;
    end
  end

  assign valid_o               = valid_q;
  assign op_o                  = out_q.op;
  assign max_sign_o            = out_q.max_sign;
  assign min_sign_o            = out_q.min_sign;
  assign max_exponent_o        = out_q.max_exp;
  assign add_result_mantissa_o = out_q.add_man;
  assign sub_result_mantissa_o = out_q.sub_man;
  assign max_result_o          = out_q.max_res;
  assign min_result_o          = out_q.min_res;
  assign result_o              = out_q.result;

endmodule

// File: tb/tb_fp_std_0.sv
// Table-driven scoreboard bench for fp_std_0 plus stall/reset sequences.
module tb_fp_std_0;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic        max_sign;
    logic        min_sign;
    logic [7:0]  max_exp;
    logic [16:0] add_man;
    logic [15:0] sub_man;
    logic [23:0] max_res;
    logic [23:0] min_res;
    logic [23:0] result;
  } exp_t;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [3:0]  op;
    exp_t        e;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, stall_i;
  logic [3:0]  op_i;
  logic [23:0] a_i, b_i;
  logic        valid_o, max_sign_o, min_sign_o;
  logic [3:0]  op_o;
  logic [7:0]  max_exponent_o;
  logic [16:0] add_result_mantissa_o;
  logic [15:0] sub_result_mantissa_o;
  logic [23:0] max_result_o, min_result_o, result_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t act;
  exp_t sb_q[$];
  vec_t vecs[$];

  fp_std_0 #(.WIDTH(24)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .op_o(op_o),
    .max_sign_o(max_sign_o), .min_sign_o(min_sign_o),
    .max_exponent_o(max_exponent_o),
    .add_result_mantissa_o(add_result_mantissa_o),
    .sub_result_mantissa_o(sub_result_mantissa_o),
    .max_result_o(max_result_o), .min_result_o(min_result_o),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  assign act = {valid_o, op_o, max_sign_o, min_sign_o, max_exponent_o,
                add_result_mantissa_o, sub_result_mantissa_o,
                max_result_o, min_result_o, result_o};

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".valid"},    32'(act.valid),    32'(e.valid));
    chk({tag, ".op"},       32'(act.op),       32'(e.op));
    chk({tag, ".max_sign"}, 32'(act.max_sign), 32'(e.max_sign));
    chk({tag, ".min_sign"}, 32'(act.min_sign), 32'(e.min_sign));
    chk({tag, ".max_exp"},  32'(act.max_exp),  32'(e.max_exp));
    chk({tag, ".add_man"},  32'(act.add_man),  32'(e.add_man));
    chk({tag, ".sub_man"},  32'(act.sub_man),  32'(e.sub_man));
    chk({tag, ".max_res"},  32'(act.max_res),  32'(e.max_res));
    chk({tag, ".min_res"},  32'(act.min_res),  32'(e.min_res));
    chk({tag, ".result"},   32'(act.result),   32'(e.result));
  endtask

  function automatic vec_t mk(input logic [23:0] a, input logic [23:0] b,
                              input logic [3:0] op, input logic ms, input logic ns,
                              input logic [7:0] ex, input logic [16:0] ad,
                              input logic [15:0] sb, input logic [23:0] mx,
                              input logic [23:0] mn);
    vec_t v;
    v.a = a; v.b = b; v.op = op;
    v.e = {1'b1, op, ms, ns, ex, ad, sb, mx, mn, a};
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic vld, input logic stl);
    a_i = v.a; b_i = v.b; op_i = v.op; valid_i = vld; stall_i = stl;
  endtask

  initial begin
    exp_t zero_e;
    exp_t x_e;
    zero_e = '{default: 1'b0};
    rst_i = 1'b1; valid_i = 1'b0; stall_i = 1'b0; op_i = 4'h0;
    a_i = 24'h000000; b_i = 24'h000000;

    //        a           b           op    ms    ns    exp    add        sub       max         min
    vecs.push_back(mk(24'h3F8000, 24'h3F8000, 4'h0, 1'b0, 1'b0, 8'h7F, 17'h10000, 16'h0000, 24'h3F8000, 24'h3F8000));
    vecs.push_back(mk(24'h3F8000, 24'h3F8000, 4'h4, 1'b0, 1'b1, 8'h7F, 17'h10000, 16'h0000, 24'h3F8000, 24'h3F8000));
    vecs.push_back(mk(24'h400000, 24'h3F8000, 4'h0, 1'b0, 1'b0, 8'h80, 17'h0C000, 16'h4000, 24'h400000, 24'h3F8000));
    vecs.push_back(mk(24'h480000, 24'h3F8000, 4'h0, 1'b0, 1'b0, 8'h90, 17'h08000, 16'h8000, 24'h480000, 24'h3F8000));
    vecs.push_back(mk(24'h3F8000, 24'hBF8000, 4'h1, 1'b0, 1'b1, 8'h7F, 17'h10000, 16'h0000, 24'h3F8000, 24'hBF8000));
    vecs.push_back(mk(24'h000000, 24'h800000, 4'h2, 1'b0, 1'b1, 8'h00, 17'h00000, 16'h0000, 24'h000000, 24'h800000));
    vecs.push_back(mk(24'hBF8000, 24'hC00000, 4'h0, 1'b1, 1'b1, 8'h80, 17'h0C000, 16'h4000, 24'hBF8000, 24'hC00000));
    vecs.push_back(mk(24'h3F8000, 24'hC00000, 4'h4, 1'b0, 1'b0, 8'h80, 17'h0C000, 16'h4000, 24'h3F8000, 24'hC00000));
    vecs.push_back(mk(24'h3FC000, 24'h3E8000, 4'h8, 1'b0, 1'b0, 8'h7F, 17'h0E000, 16'hA000, 24'h3FC000, 24'h3E8000));
    vecs.push_back(mk(24'h477FFF, 24'h3F8000, 4'h0, 1'b0, 1'b0, 8'h8E, 17'h10000, 16'hFFFE, 24'h477FFF, 24'h3F8000));
    vecs.push_back(mk(24'h478000, 24'h3F8000, 4'h0, 1'b0, 1'b0, 8'h8F, 17'h08000, 16'h8000, 24'h478000, 24'h3F8000));
    vecs.push_back(mk(24'h000003, 24'h000001, 4'h0, 1'b0, 1'b0, 8'h00, 17'h00004, 16'h0002, 24'h000003, 24'h000001));
    vecs.push_back(mk(24'h7FFFFF, 24'h7FFFFF, 4'h0, 1'b0, 1'b0, 8'hFF, 17'h1FFFE, 16'h0000, 24'h7FFFFF, 24'h7FFFFF));
    vecs.push_back(mk(24'h3F8000, 24'h3F8000, 4'h7, 1'b0, 1'b0, 8'h7F, 17'h10000, 16'h0000, 24'h3F8000, 24'h3F8000));

    repeat (2) @(negedge clk_i);
    chk_all("reset", zero_e);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i], 1'b1, 1'b0);
      sb_q.push_back(vecs[i].e);
      @(negedge clk_i);
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        chk_all($sformatf("vec%0d", i), sb_q.pop_front());
      end
    end

    // Stall: X captured, then Y presented under stall must not disturb X
    x_e = vecs[2].e;
    drive(vecs[2], 1'b1, 1'b0);
    @(negedge clk_i);
    chk_all("stall_x", x_e);
    for (int k = 0; k < 3; k++) begin
      drive(vecs[6], 1'b1, 1'b1);
      @(negedge clk_i);
      chk_all($sformatf("stall_hold%0d", k), x_e);
    end
    // Release without re-presenting Y: nothing new is valid
    drive(vecs[6], 1'b0, 1'b0);
    @(negedge clk_i);
    chk("release_valid", 32'(valid_o), 32'd0);

    // Reset during a stall clears everything on the next edge
    drive(vecs[3], 1'b1, 1'b0);
    @(negedge clk_i);
    chk_all("pre_rst", vecs[3].e);
    drive(vecs[4], 1'b1, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk_all("rst_in_stall", zero_e);
    rst_i = 1'b0;
    drive(vecs[0], 1'b0, 1'b0);
    @(negedge clk_i);
    chk("post_rst_valid", 32'(valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_std_0.md
# fp_std_0

First stage of the two-stage 24-bit floating-point add/sub/max/min pipe; it feeds `fp_std_1`. It takes raw operands and performs the following:
- unpacks both operands;
- orders them by magnitude;
- aligns the smaller mantissa;
- forms both the raw sum and the raw difference;
- selects the signed max/min.

All outputs are held in a stallable pipeline register, with a valid bit, that drives `fp_std_1` directly. Number format is 1 sign, 8-bit exponent (bias 127), 15-bit fraction, with a hidden bit when exponent ≠ 0.

## Interface
- `WIDTH`, default 24: operand and result width; only 24 is supported.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  operands on `a_i`/`b_i`/`op_i` are valid this cycle.
- `stall_i`  in  1  hold the output register; the input is ignored while high.
- `op_i`  in  4  operation: [1:0] 00 add/sub, 01 max, 10 min, 11 reserved; [2] subtract (negate b); [3] unused, passed through.
- `a_i`, `b_i`  in  WIDTH  operands.
- `valid_o`  out  1  registered outputs are valid.
- `op_o`  out  4  registered `op_i`.
- `max_sign_o`, `min_sign_o`  out  1  signs of the larger- and smaller-magnitude operands (b after negation).
- `max_exponent_o`  out  8  exponent of the larger-magnitude operand.
- `add_result_mantissa_o`  out  17  {0,max_man} + {0,aligned_min_man}.
- `sub_result_mantissa_o`  out  16  max_man − aligned_min_man.
- `max_result_o`, `min_result_o`  out  WIDTH  signed numeric max and min of a and b (b not negated).
- `result_o`  out  WIDTH  registered `a_i`; spare bypass path for later ops.

## Operation
- **Unpack.** man = {exp≠0, frac[14:0]} (16 bits). b′ = b with sign XOR `op_i[2]`, applied only when `op_i[1:0]`=00.
- **Magnitude order.** Compare {exp,frac} of a and b′ as unsigned 23-bit values. The larger value is "max"; a tie selects a as max.
- **Alignment.**
  - diff = max_exp − min_exp (8-bit, never negative).
  - aligned_min_man = min_man >> diff.
  - diff ≥ 16 gives 0.
  - Truncating; no guard or sticky bits.
- **Arithmetic.**
  - The sum is 17 bits and the carry is kept.
  - The difference is 16 bits and is always ≥ 0 by construction.
  - Equal magnitudes give 0; `fp_std_1` then yields exponent 0.
- **Signed max/min.**
  - Signs differ: the positive operand is max. +0 vs −0: +0 is max.
  - Both positive: larger magnitude is max.
  - Both negative: smaller magnitude is max.
  - Exact equality: max = min = a.
- **Special values.** NaN and Inf are not special-cased; they are treated as ordinary encodings.

## Timing
- The stage holds a single register bank, so latency is 1 cycle from `valid_i` to `valid_o`. End-to-end latency through `fp_std_1` is 2 cycles.
- **Normal cycle:** `stall_i`=0 means every register loads on each clock edge, and `valid_o` ← `valid_i`. Data registers load even when `valid_i`=0; downstream qualifies with `valid_o`.
- **Stall:** `stall_i`=1 means all registers, including `valid_o`, hold. The input is dropped; the upstream must hold its request.
- **Reset:** `rst_i`=1 at an edge clears all outputs to 0, including `valid_o`. Reset overrides `stall_i`. Reset in the middle of a stream discards the in-flight operand.
- **Simultaneous `valid_i` and `stall_i`:** the input is not captured.

## Structure
- **Package `fp_pkg`:**
  - constants FP_EXP_W=8, FP_MAN_W=15, FP_BIAS=127;
  - op encodings FP_OP_ADD=2'b00, FP_OP_MAX=2'b01, FP_OP_MIN=2'b10;
  - typedef `fp24_t` packed {sign, exp, frac}.
- **Sub-module `fp_align_shift`:** a combinational 16-bit right shifter with saturation to 0 for shift ≥ 16. It is reused by later stages.

## Test plan
- **Equal add:** a=b=0x3F8000 (1.0), op=0000 → next cycle valid_o=1, max_exponent_o=0x7F, add_result_mantissa_o=0x10000, signs both 0.
- **Subtract to zero:** a=b=0x3F8000, op=0100 → min_sign_o=1, max_sign_o=0, sub_result_mantissa_o=0x0000.
- **Align by one:** a=0x400000 (2.0), b=0x3F8000, op=0000 → max_exponent_o=0x80, add_result_mantissa_o=0x0C000, sub_result_mantissa_o=0x4000.
- **Large exponent gap:** a exp 0x90, frac 0; b=0x3F8000 → aligned min is 0, so add_result_mantissa_o=0x08000 and sub_result_mantissa_o=0x8000.
- **Max/min:** a=0x3F8000, b=0xBF8000, op=0001 → max_result_o=0x3F8000, min_result_o=0xBF8000. Repeat with a=0x000000, b=0x800000 → max 0x000000, min 0x800000.
- **Stall and reset:**
  - Issue op X, then stall_i=1 for 3 cycles while presenting op Y → outputs hold X.
  - Release → Y is not captured unless it is re-presented.
  - rst_i pulsed during a stall → all outputs 0, valid_o=0, on the next edge.
